morra_cinese: RTL and testbench

- Two-player rock-paper-scissors ("morra cinese") referee, implemented as a small FSM with datapath (FSMD).
- Each clock cycle is one round. The block takes both players' moves, reports the round result (MANCHE) and the match result (PARTITA).
- INIZIA restarts a match and loads the maximum number of rounds.
- Outputs are Mealy: combinational from the current inputs and the registered state.

---
 rtl/morra_cinese.sv | 62 ++++++
 tb/tb_morra_cinese.sv | 98 +++++++++
 2 files changed

// File: rtl/morra_cinese.sv
// morra_cinese: two-player rock-paper-scissors referee reporting round and match results
module morra_cinese #(
  parameter int MIN_ROUNDS = 4,
  parameter int WIN_MARGIN = 2
) (
  input  logic       clk,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);
  localparam logic [4:0] MIN_R = 5'(MIN_ROUNDS);
  localparam logic [4:0] MARGIN = 5'(WIN_MARGIN);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state_q, state_d;
  logic [4:0] max_q, played_q, played_d, s1_q, s1_d, s2_q, s2_d;
  logic [1:0] lw_q, lw_d, lwm_q, lwm_d;
  logic p1_beats, valid;
  logic [1:0] res, end_res;
  logic [4:0] p_n, s1_n, s2_n, diff;
  always_comb begin
    p1_beats = (PRIMO == 2'b01 && SECONDO == 2'b11) || (PRIMO == 2'b11 && SECONDO == 2'b10) ||
               (PRIMO == 2'b10 && SECONDO == 2'b01);
    // a player who just won may not repeat the winning move until a draw clears it
    valid = state_q == PLAY && PRIMO != 2'b00 && SECONDO != 2'b00 &&
            !(lw_q == 2'b01 && PRIMO == lwm_q) && !(lw_q == 2'b10 && SECONDO == lwm_q);
    res = PRIMO == SECONDO ? 2'b11 : p1_beats ? 2'b01 : 2'b10;
    p_n = played_q + 5'd1;
    s1_n = s1_q + {4'b0, res == 2'b01};
    s2_n = s2_q + {4'b0, res == 2'b10};
    diff = s1_n > s2_n ? s1_n - s2_n : s2_n - s1_n;
    end_res = (p_n >= MIN_R && diff >= MARGIN) ? (s1_n > s2_n ? 2'b01 : 2'b10) :
              p_n == max_q ? (s1_n > s2_n ? 2'b01 : s2_n > s1_n ? 2'b10 : 2'b11) : 2'b00;
    MANCHE = !INIZIA && valid ? res : 2'b00;
    PARTITA = !INIZIA && valid ? end_res : 2'b00;
    state_d = valid && end_res != 2'b00 ? IDLE : state_q;
    played_d = valid ? p_n : played_q;
    s1_d = valid ? s1_n : s1_q;
    s2_d = valid ? s2_n : s2_q;
    lw_d = valid ? (res == 2'b11 ? 2'b00 : res) : lw_q;
    lwm_d = valid ? (res == 2'b01 ? PRIMO : SECONDO) : lwm_q;
  end
  always_ff @(posedge clk) begin
    if (INIZIA) begin
      state_q <= PLAY;
      max_q <= {1'b0, PRIMO, SECONDO} + 5'd4;
      played_q <= 5'd0;
      s1_q <= 5'd0;
      s2_q <= 5'd0;
      lw_q <= 2'b00;
      lwm_q <= 2'b00;
    end else begin
      state_q <= state_d;
      played_q <= played_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      lw_q <= lw_d;
      lwm_q <= lwm_d;
    end
  end
endmodule

// File: tb/tb_morra_cinese.sv
// tb_morra_cinese: directed rounds with a queued scoreboard checked by an independent monitor
module tb_morra_cinese;
  logic clk = 0;
  logic inizia = 0;
  logic [1:0] primo = 0, secondo = 0, manche, partita;
  int checks = 0, failures = 0;
  typedef struct {
    string name;
    logic [1:0] m;
    logic [1:0] p;
  } exp_t;
  exp_t q[$];

  morra_cinese dut (
    .clk(clk), .INIZIA(inizia), .PRIMO(primo), .SECONDO(secondo),
    .MANCHE(manche), .PARTITA(partita)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (manche !== e.m || partita !== e.p) begin
        failures++;
        $display("FAIL %s: got %b/%b expected %b/%b", e.name, manche, partita, e.m, e.p);
      end
    end
  end

  task automatic step(input string name, input logic i, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] m, input logic [1:0] p);
    exp_t e;
    @(posedge clk);
    #1;
    inizia = i;
    primo = a;
    secondo = b;
    e.name = name;
    e.m = m;
    e.p = p;
    q.push_back(e);
  endtask

  initial begin
    step("stale_init", 1, 2'b10, 2'b01, 2'b00, 2'b00);
    step("stale_nomove", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    step("stale_p1win", 0, 2'b10, 2'b01, 2'b01, 2'b00);
    step("stale_p2win", 0, 2'b11, 2'b01, 2'b10, 2'b00);
    step("stale_p1none", 0, 2'b00, 2'b10, 2'b00, 2'b00);
    step("stale_p2repeat", 0, 2'b01, 2'b01, 2'b00, 2'b00);
    step("stale_p2repeat2", 0, 2'b01, 2'b01, 2'b00, 2'b00);
    step("stale_p2repeat3", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    step("margin_init", 1, 2'b00, 2'b01, 2'b00, 2'b00);
    step("margin_r1", 0, 2'b01, 2'b10, 2'b10, 2'b00);
    step("margin_r2", 0, 2'b11, 2'b01, 2'b10, 2'b00);
    step("margin_r3_early", 0, 2'b10, 2'b11, 2'b10, 2'b00);
    step("margin_r4_end", 0, 2'b11, 2'b10, 2'b01, 2'b10);
    step("postend_a", 0, 2'b01, 2'b10, 2'b00, 2'b00);
    step("postend_b", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    step("draws_init", 1, 2'b00, 2'b01, 2'b00, 2'b00);
    step("draws_r1", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("draws_r2", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("draws_r3", 0, 2'b11, 2'b01, 2'b10, 2'b00);
    step("draws_r4_end", 0, 2'b10, 2'b11, 2'b10, 2'b10);
    step("max_init", 1, 2'b00, 2'b01, 2'b00, 2'b00);
    step("max_r1", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("max_r2", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("max_r3", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("max_r4", 0, 2'b11, 2'b01, 2'b10, 2'b00);
    step("max_r5_level", 0, 2'b01, 2'b11, 2'b01, 2'b11);
    step("max_postend", 0, 2'b01, 2'b11, 2'b00, 2'b00);
    step("mid_init", 1, 2'b00, 2'b01, 2'b00, 2'b00);
    step("mid_r1", 0, 2'b01, 2'b11, 2'b01, 2'b00);
    step("mid_restart", 1, 2'b00, 2'b00, 2'b00, 2'b00);
    step("mid_r1b", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("mid_r2b_p1rock", 0, 2'b01, 2'b11, 2'b01, 2'b00);
    step("mid_r3b", 0, 2'b11, 2'b11, 2'b11, 2'b00);
    step("mid_r4b_max", 0, 2'b11, 2'b11, 2'b11, 2'b01);
    step("mid_postend", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    inizia = 0;
    primo = 0;
    secondo = 0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
